// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the program counter, reads the combinational
// instruction memory and queues {instr, pc} pairs in a 2-entry buffer for decode.
module instruction_fetch #(
  parameter int                     BITS        = 32,
  parameter int                     i_addr_bits = 6,
  parameter logic [i_addr_bits-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_en,
  output logic [i_addr_bits-3:0] mem_addr,
  input  logic [BITS-1:0]        mem_data,
  input  logic                   redirect_valid,
  input  logic [i_addr_bits-1:0] redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS-1:0]        out_instr,
  output logic [i_addr_bits-1:0] out_pc
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [i_addr_bits-1:0] PC_STEP = i_addr_bits'(4);

  logic [i_addr_bits-1:0] pc;
  logic [1:0]             count;
  logic                   head;
  logic                   tail;
  logic [BITS-1:0]        buf_instr [2];
  logic [i_addr_bits-1:0] buf_pc    [2];

  logic pop;
  logic push;

  // Low PC bits of a redirect target are forced to zero, so they are never read.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign out_valid = (count != EMPTY);
  assign pop       = out_valid && out_ready;
  assign push      = fetch_en && !redirect_valid && ((count != FULL) || pop);

  assign mem_addr  = pc[i_addr_bits-1:2];
  assign out_instr = buf_instr[head];
  assign out_pc    = buf_pc[head];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[i_addr_bits-1:2], 2'b00};
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  // Occupancy and pointers; a redirect discards everything still buffered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= EMPTY;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else if (redirect_valid) begin
      count <= EMPTY;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (push && !pop) begin
        count <= (count == EMPTY) ? ONE : FULL;
      end else if (pop && !push) begin
        count <= (count == FULL) ? ONE : EMPTY;
      end
      if (pop) begin
        head <= ~head;
      end
      if (push) begin
        tail <= ~tail;
      end
    end
  end

  // NOTE: the buffer storage is reset on purpose: out_instr/out_pc must read
  // zero straight out of reset, and the storage is only two entries deep.
  // In FULL with a simultaneous pop, tail equals head; the overwrite is safe
  // because decode consumes the old head value in this same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else if (push) begin
      buf_instr[tail] <= mem_data;
      buf_pc[tail]    <= pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// traffic compared against a queue-based model of the fetch buffer.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [3:0]  mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [5:0]  out_pc;

  logic [31:0] imem [16];

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  pc;
  } entry_t;

  entry_t     q[$];
  logic [5:0] mpc;

  int checks   = 0;
  int failures = 0;

  assign mem_data = imem[mem_addr];

  always #5 clk = ~clk;

  instruction_fetch #(.BITS(32), .i_addr_bits(6), .RESET_PC(6'd0)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  // Applies one cycle of inputs, advances the model by the fetch rules, then
  // clocks the DUT and waits past the edge so outputs can be sampled.
  task automatic drive_cycle(input logic fe, input logic rv, input logic [5:0] rpc,
                             input logic rdy);
    bit     do_pop;
    bit     do_push;
    entry_t e;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    do_pop  = (q.size() != 0) && rdy;
    do_push = fe && !rv && ((q.size() < 2) || do_pop);
    e.instr = imem[mpc[5:2]];
    e.pc    = mpc;
    if (do_pop) void'(q.pop_front());
    if (rv) begin
      q.delete();
      mpc = {rpc[5:2], 2'b00};
    end else if (do_push) begin
      q.push_back(e);
      mpc = mpc + 6'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fetch_en = 0; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    reset = 1'b1;
    q.delete();
    mpc = 6'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 6'd0 || out_instr !== 32'd0 || mem_addr !== 4'd0) begin
      failures++;
      $display("FAIL reset: valid=%b pc=%h instr=%h addr=%h, required 0 0 0 0",
               out_valid, out_pc, out_instr, mem_addr);
    end
  endtask

  task automatic test_stream();
    drive_cycle(1, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h000000B3 || out_pc !== 6'd0) begin
      failures++;
      $display("FAIL stream_first: valid=%b instr=%h pc=%h, required 1 000000b3 00",
               out_valid, out_instr, out_pc);
    end
    drive_cycle(1, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h40100133 || out_pc !== 6'd4) begin
      failures++;
      $display("FAIL stream_second: valid=%b instr=%h pc=%h, required 1 40100133 04",
               out_valid, out_instr, out_pc);
    end
    for (int i = 2; i < 6; i++) begin
      drive_cycle(1, 0, 0, 1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 6'(4 * i) || out_instr !== imem[i]) begin
        failures++;
        $display("FAIL stream_rate: valid=%b pc=%h instr=%h, required 1 %h %h",
                 out_valid, out_pc, out_instr, 6'(4 * i), imem[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, 0, 0, 0);
      if (i >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 6'd0 || mem_addr !== 4'd2) begin
          failures++;
          $display("FAIL backpressure_hold: valid=%b head_pc=%h addr=%h, required 1 00 2",
                   out_valid, out_pc, mem_addr);
        end
      end
    end
    for (int i = 1; i < 3; i++) begin
      drive_cycle(1, 0, 0, 1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 6'(4 * i)) begin
        failures++;
        $display("FAIL backpressure_order: valid=%b pc=%h, required 1 %h",
                 out_valid, out_pc, 6'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 1, 6'h2B, 1);
    checks++;
    if (out_valid !== 1'b0 || mem_addr !== 4'd10) begin
      failures++;
      $display("FAIL redirect_flush: valid=%b addr=%h, required 0 a", out_valid, mem_addr);
    end
    drive_cycle(1, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 6'h28 || out_instr !== imem[10]) begin
      failures++;
      $display("FAIL redirect_target: valid=%b pc=%h instr=%h, required 1 28 %h",
               out_valid, out_pc, out_instr, imem[10]);
    end
  endtask

  task automatic test_wrap();
    drive_cycle(1, 1, 6'd60, 1);
    checks++;
    if (mem_addr !== 4'd15 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_redirect: addr=%h valid=%b, required f 0", mem_addr, out_valid);
    end
    drive_cycle(1, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 6'd60 || mem_addr !== 4'd0) begin
      failures++;
      $display("FAIL wrap_top: valid=%b pc=%0d addr=%0d, required 1 60 0", out_valid, out_pc, mem_addr);
    end
    drive_cycle(1, 0, 0, 1);
    checks++;
    if (out_pc !== 6'd0 || mem_addr !== 4'd1 || out_instr !== imem[0]) begin
      failures++;
      $display("FAIL wrap_zero: pc=%0d addr=%0d instr=%h, required 0 1 %h",
               out_pc, mem_addr, out_instr, imem[0]);
    end
    drive_cycle(1, 0, 0, 1);
    checks++;
    if (out_pc !== 6'd4) begin
      failures++;
      $display("FAIL wrap_next: pc=%0d, required 4", out_pc);
    end
  endtask

  task automatic test_fetch_disable();
    do_reset();
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 6'd4 || mem_addr !== 4'd2) begin
      failures++;
      $display("FAIL disable_pop1: valid=%b pc=%h addr=%h, required 1 04 2", out_valid, out_pc, mem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(0, 0, 0, 1);
      checks++;
      if (out_valid !== 1'b0 || mem_addr !== 4'd2) begin
        failures++;
        $display("FAIL disable_drained: valid=%b addr=%h, required 0 2", out_valid, mem_addr);
      end
    end
    drive_cycle(1, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 6'd8 || out_instr !== imem[2]) begin
      failures++;
      $display("FAIL disable_resume: valid=%b pc=%h instr=%h, required 1 08 %h",
               out_valid, out_pc, out_instr, imem[2]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                  6'($urandom), ($urandom_range(0, 2) != 0));
      checks++;
      if (out_valid !== (q.size() != 0) || mem_addr !== mpc[5:2]) begin
        failures++;
        $display("FAIL random_state cycle %0d: valid=%b addr=%h, required %b %h",
                 n, out_valid, mem_addr, (q.size() != 0), mpc[5:2]);
      end
      if (q.size() != 0) begin
        checks++;
        if (out_pc !== q[0].pc || out_instr !== q[0].instr) begin
          failures++;
          $display("FAIL random_head cycle %0d: pc=%h instr=%h, required %h %h",
                   n, out_pc, out_instr, q[0].pc, q[0].instr);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 1, 6'd20, 1);
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 6'd20) begin
      failures++;
      $display("FAIL async_pre: valid=%b pc=%h, required 1 14", out_valid, out_pc);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 6'd0 || out_instr !== 32'd0 || mem_addr !== 4'd0) begin
      failures++;
      $display("FAIL async_reset: valid=%b pc=%h instr=%h addr=%h, required 0 0 0 0",
               out_valid, out_pc, out_instr, mem_addr);
    end
    q.delete();
    mpc = 6'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_cycle(1, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 6'd0 || out_instr !== imem[0]) begin
      failures++;
      $display("FAIL async_restart: valid=%b pc=%h instr=%h, required 1 00 %h",
               out_valid, out_pc, out_instr, imem[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = $urandom;
    imem[0] = 32'h000000B3;
    imem[1] = 32'h40100133;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_wrap();
    test_fetch_disable();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
